// File: rtl/bs_pkg.sv
// rtl/bs_pkg.sv - shared types and constants for the bit-serial ALU sequencer
package bs_pkg;

  localparam int GPR_WIDTH = 8;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    MOV = 3'b101,
    NOT = 3'b110,
    CLR = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bs_alu_bit.sv
// rtl/bs_alu_bit.sv - combinational one-bit ALU slice used by the serial sequencer
module bs_alu_bit
  import bs_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  output logic       o_res,
  output logic       o_cout
);

  alu_op_t w_op;
  logic    w_b;

  assign w_op = alu_op_t'(i_op);
  // Subtraction is acc + ~gpr + 1; the +1 comes from the carry preset at start.
  assign w_b  = (w_op == SUB) ? ~i_b : i_b;

  always_comb begin
    o_res  = 1'b0;
    o_cout = 1'b0;
    case (w_op)
      ADD, SUB: begin
        o_res  = i_a ^ w_b ^ i_cin;
        o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);
      end
      AND:     o_res = i_a & i_b;
      OR:      o_res = i_a | i_b;
      XOR:     o_res = i_a ^ i_b;
      MOV:     o_res = i_b;
      NOT:     o_res = ~i_b;
      CLR:     o_res = 1'b0;
      default: o_res = 1'b0;
    endcase
  end

endmodule

// File: rtl/bs_alu_seq.sv
// rtl/bs_alu_seq.sv - bit-serial ALU and sequencer driving the shift-register GPR file
module bs_alu_seq
  import bs_pkg::*;
#(
  parameter int WIDTH = GPR_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic             i_dest_gpr,
  input  logic             i_gpr_bit,
  output logic             o_con_shift,
  output logic             o_con_write,
  output logic             o_data_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_carry,
  output logic             o_zero
);

  state_t           r_state;
  state_t           w_state_nxt;
  alu_op_t          r_op;
  logic             r_dest;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry_ff;
  logic             r_zero_acc;
  logic             r_carry;
  logic             r_zero;

  logic             w_run;
  logic             w_last;
  logic             w_res;
  logic             w_cout;

  assign w_run  = (r_state == RUN);
  assign w_last = (r_count == CNT_W'(WIDTH - 1));

  bs_alu_bit u_alu_bit (
    .i_op   (r_op),
    .i_a    (r_acc[0]),
    .i_b    (i_gpr_bit),
    .i_cin  (r_carry_ff),
    .o_res  (w_res),
    .o_cout (w_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = RUN;
      RUN:     if (w_last)  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op       <= ADD;
      r_dest     <= 1'b0;
      r_count    <= '0;
      r_acc      <= '0;
      r_carry_ff <= 1'b0;
      r_zero_acc <= 1'b0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_op       <= alu_op_t'(i_op);
        r_dest     <= i_dest_gpr;
        r_count    <= '0;
        r_zero_acc <= 1'b0;
        r_carry_ff <= (alu_op_t'(i_op) == SUB);
      end
      if (w_run) begin
        // When the result goes to the GPR the accumulator just rotates back into place.
        r_acc      <= {(r_dest ? r_acc[0] : w_res), r_acc[WIDTH-1:1]};
        r_carry_ff <= w_cout;
        r_zero_acc <= r_zero_acc | w_res;
        r_count    <= r_count + 1'b1;
        if (w_last) begin
          r_carry <= w_cout;
          r_zero  <= ~(r_zero_acc | w_res);
        end
      end
    end
  end

  assign o_busy      = w_run;
  assign o_con_shift = w_run;
  assign o_con_write = w_run & r_dest;
  assign o_data_in   = w_run & w_res;
  assign o_done      = (r_state == DONE);
  assign o_acc       = r_acc;
  assign o_carry     = r_carry;
  assign o_zero      = r_zero;

endmodule
